// File: rtl/pool_module.sv
// pool_module: 2x2 max-pool over a CH-channel IW x IW conv map.
// A map is captured on the accepting edge, then one pooled element is produced
// per cycle; the finished map is held until the consumer takes it.
// Optional feature: define POOL_RELU_EN to treat elements as signed two's
// complement and clamp each one at zero before pooling (fused ReLU).
// Without it, elements are unsigned and no clamp is applied.
module pool_module #(
  parameter int DW = 8,
  parameter int CH = 3,
  parameter int IW = 6
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [IW*IW*CH*DW-1:0]           conv_lin,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [(IW/2)*(IW/2)*CH*DW-1:0]   pool_lin
);

  localparam int HW  = IW / 2;
  localparam int NB  = IW * IW * CH;
  localparam int NP  = HW * HW * CH;
  localparam int BW  = (NB > 1) ? $clog2(NB) : 1;
  localparam int CW  = (NP > 1) ? $clog2(NP) : 1;
  localparam int HWW = (HW > 1) ? $clog2(HW) : 1;
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

  localparam logic [BW-1:0]  PLANE_STEP   = BW'(IW * IW);
  localparam logic [BW-1:0]  ROW_STEP     = BW'(IW);
  localparam logic [BW-1:0]  WIN_ROW_STEP = BW'(2 * IW);
  localparam logic [BW-1:0]  WIN_COL_STEP = BW'(2);
  localparam logic [CW-1:0]  CNT_LAST     = CW'(NP - 1);
  localparam logic [HWW-1:0] POS_LAST     = HWW'(HW - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg;
  logic [CHW-1:0]  ch_reg;
  logic [HWW-1:0]  pr_reg;
  logic [HWW-1:0]  pc_reg;
  logic [DW-1:0]   conv_elem  [NB];
  logic [DW-1:0]   buffer_reg [NB];
  logic [DW-1:0]   pool_reg   [NP];
  logic [BW-1:0]   win_base;
  logic [DW-1:0]   win_max;
  logic            accept;
  logic            calc_last;

  // Clamp applied to every element before it enters the window compare.
  // After clamping all values are non-negative, so a plain unsigned compare
  // gives the right ordering in both builds.
  function automatic logic [DW-1:0] clamp(input logic [DW-1:0] x);
`ifdef POOL_RELU_EN
    clamp = x[DW-1] ? '0 : x;
`else
    clamp = x;
`endif
  endfunction

  function automatic logic [DW-1:0] max2(input logic [DW-1:0] a, input logic [DW-1:0] b);
    max2 = (a > b) ? a : b;
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NB; gi++) begin : g_unpack
      assign conv_elem[gi] = conv_lin[gi*DW +: DW];
    end
    for (gi = 0; gi < NP; gi++) begin : g_pack
      assign pool_lin[gi*DW +: DW] = pool_reg[gi];
    end
  endgenerate

  assign accept    = (state_reg == IDLE) && in_valid;
  assign calc_last = (state_reg == CALC) && (cnt_reg == CNT_LAST);

  // Window select: top-left corner of the 2x2 window for the current element,
  // then max over the four clamped values.
  always_comb begin
    win_base = BW'(ch_reg) * PLANE_STEP + BW'(pr_reg) * WIN_ROW_STEP + BW'(pc_reg) * WIN_COL_STEP;
    win_max  = max2(max2(clamp(buffer_reg[win_base]),
                         clamp(buffer_reg[win_base + BW'(1)])),
                    max2(clamp(buffer_reg[win_base + ROW_STEP]),
                         clamp(buffer_reg[win_base + ROW_STEP + BW'(1)])));
  end

  // Next-state and handshake decode; handshake outputs depend on state only.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = CALC;
      end
      CALC: begin
        if (calc_last) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_reg <= IDLE;
    else        state_reg <= state_next;
  end

  // Element counter plus its (channel, row, col) decomposition; holds on the last element.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
      ch_reg  <= '0;
      pr_reg  <= '0;
      pc_reg  <= '0;
    end else if (accept) begin
      cnt_reg <= '0;
      ch_reg  <= '0;
      pr_reg  <= '0;
      pc_reg  <= '0;
    end else if ((state_reg == CALC) && !calc_last) begin
      cnt_reg <= cnt_reg + CW'(1);
      if (pc_reg == POS_LAST) begin
        pc_reg <= '0;
        if (pr_reg == POS_LAST) begin
          pr_reg <= '0;
          ch_reg <= ch_reg + CHW'(1);
        end else begin
          pr_reg <= pr_reg + HWW'(1);
        end
      end else begin
        pc_reg <= pc_reg + HWW'(1);
      end
    end
  end

  // Input buffer: captured only on the accepting edge, so later input changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NB; i++) buffer_reg[i] <= '0;
    end else if (accept) begin
      for (int i = 0; i < NB; i++) buffer_reg[i] <= conv_elem[i];
    end
  end

  // Pooled result: one element written per CALC cycle, everything else holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NP; i++) pool_reg[i] <= '0;
    end else if (state_reg == CALC) begin
      pool_reg[cnt_reg] <= win_max;
    end
  end

endmodule

// File: tb/tb_pool_module.sv
// Self-checking bench for pool_module: a frame-level reference model predicts
// the handshake outputs and every pool_lin element each cycle; directed
// scenarios add hand-computed literal expectations.
module tb_pool_module;

  localparam int DW   = 8;
  localparam int CH   = 3;
  localparam int IW   = 6;
  localparam int HW   = IW / 2;
  localparam int NB   = IW * IW * CH;
  localparam int NP   = HW * HW * CH;
  localparam int CWID = NB * DW;
  localparam int PWID = NP * DW;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            in_valid;
  logic            in_ready;
  logic [CWID-1:0] conv_lin;
  logic            out_valid;
  logic            out_ready;
  logic [PWID-1:0] pool_lin;

  pool_module #(.DW(DW), .CH(CH), .IW(IW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .conv_lin (conv_lin),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .pool_lin (pool_lin)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Golden pooled map computed straight from the window definition.
  function automatic logic [PWID-1:0] pool_of(input logic [CWID-1:0] m);
    logic [PWID-1:0] r;
    int best;
    int v;
    r = '0;
    for (int c = 0; c < CH; c++)
      for (int pr = 0; pr < HW; pr++)
        for (int pc = 0; pc < HW; pc++) begin
          best = -1;
          for (int dr = 0; dr < 2; dr++)
            for (int dc = 0; dc < 2; dc++) begin
              v = int'(m[(c*IW*IW + (2*pr+dr)*IW + 2*pc + dc)*DW +: DW]);
`ifdef POOL_RELU_EN
              if (v >= (1 << (DW-1))) v = 0;
`endif
              if (v > best) best = v;
            end
          r[(c*HW*HW + pr*HW + pc)*DW +: DW] = best[DW-1:0];
        end
    return r;
  endfunction

  function automatic logic [CWID-1:0] rand_map();
    logic [CWID-1:0] r;
    for (int i = 0; i < NB; i++) r[i*DW +: DW] = DW'($urandom);
    return r;
  endfunction

  // Frame-level model: 0 = waiting, 1 = computing (m_timer elements done), 2 = result held.
  int              m_phase = 0;
  int              m_timer = 0;
  int              m_done  = 0;
  logic [PWID-1:0] m_prev  = '0;
  logic [PWID-1:0] m_new   = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_timer <= 0;
      m_prev  <= '0;
      m_new   <= '0;
    end else begin
      case (m_phase)
        0: if (in_valid) begin
          m_prev  <= m_new;
          m_new   <= pool_of(conv_lin);
          m_phase <= 1;
          m_timer <= 0;
        end
        1: begin
          m_timer <= m_timer + 1;
          if (m_timer + 1 == NP) m_phase <= 2;
        end
        default: if (out_ready) begin
          m_phase <= 0;
          m_done  <= m_done + 1;
        end
      endcase
    end
  end

  // Literal expectations posted by the stimulus process, checked below.
  int              lit_seq  = 0;
  int              lit_seen = 0;
  string           lit_name = "";
  logic [PWID-1:0] lit_got  = '0;
  logic [PWID-1:0] lit_exp  = '0;

  // Compare process: every cycle against the model, plus any posted literal check.
  always @(negedge clk) begin
    logic [PWID-1:0] exp_v;
    exp_v = m_new;
    if (m_phase == 1)
      for (int k = m_timer; k < NP; k++) exp_v[k*DW +: DW] = m_prev[k*DW +: DW];

    n_checks++;
    if (in_ready !== 1'(m_phase == 0)) begin
      n_fail++;
      $display("FAIL in_ready t=%0t: got %b want %b", $time, in_ready, m_phase == 0);
    end
    n_checks++;
    if (out_valid !== 1'(m_phase == 2)) begin
      n_fail++;
      $display("FAIL out_valid t=%0t: got %b want %b", $time, out_valid, m_phase == 2);
    end
    n_checks++;
    if (pool_lin !== exp_v) begin
      n_fail++;
      $display("FAIL pool_lin t=%0t: got %0h want %0h", $time, pool_lin, exp_v);
    end

    if (lit_seq != lit_seen) begin
      lit_seen = lit_seq;
      n_checks++;
      if (lit_got !== lit_exp) begin
        n_fail++;
        $display("FAIL %s t=%0t: got %0h want %0h", lit_name, $time, lit_got, lit_exp);
      end
    end
  end

  task automatic post(input string name, input logic [PWID-1:0] got, input logic [PWID-1:0] want);
    lit_name = name;
    lit_got  = got;
    lit_exp  = want;
    lit_seq++;
    @(negedge clk);
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse(input logic [CWID-1:0] m);
    conv_lin = m;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    if (out_valid !== 1'b1) post("timeout_out_valid", PWID'(out_valid), PWID'(1));
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (in_ready !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    if (in_ready !== 1'b1) post("timeout_in_ready", PWID'(in_ready), PWID'(1));
  endtask

  initial begin
    logic [CWID-1:0] map;
    logic [PWID-1:0] expv;
    logic [PWID-1:0] want;
    int lat;
    int bad;
    int guard;
    int start_done;
    int dq[$];

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    conv_lin  = '0;
    repeat (3) tick();
    post("reset_in_ready", PWID'(in_ready), PWID'(1));
    post("reset_out_valid", PWID'(out_valid), PWID'(0));
    post("reset_pool", pool_lin, PWID'(0));

    // Ramp map: latency and two hand-computed elements.
    rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < NB; i++) map[i*DW +: DW] = DW'(i % 256);
    expv = pool_of(map);
    post("model_ramp_p000", PWID'(expv[0 +: DW]), PWID'(7));
    post("model_ramp_p222", PWID'(expv[(2*HW*HW + 2*HW + 2)*DW +: DW]), PWID'(107));
    pulse(map);
    wait_valid(60, lat);
    want = pool_lin;
    post("ramp_latency", PWID'(lat), PWID'(NP));
    post("ramp_p000", PWID'(want[0 +: DW]), PWID'(7));
    post("ramp_p222", PWID'(want[(2*HW*HW + 2*HW + 2)*DW +: DW]), PWID'(107));

    // Clamp window in channel 0 at (0,0).
    wait_idle(60);
    map = rand_map();
    map[0*DW +: DW] = 8'h80;
    map[1*DW +: DW] = 8'hFE;
    map[6*DW +: DW] = 8'h05;
    map[7*DW +: DW] = 8'h03;
`ifdef POOL_RELU_EN
    want = PWID'(8'h05);
`else
    want = PWID'(8'hFE);
`endif
    expv = pool_of(map);
    post("model_clamp", PWID'(expv[0 +: DW]), want);
    pulse(map);
    wait_valid(60, lat);
    post("clamp_p000", PWID'(pool_lin[0 +: DW]), want);

    // All-equal map.
    wait_idle(60);
    for (int i = 0; i < NB; i++) map[i*DW +: DW] = 8'h40;
    for (int k = 0; k < NP; k++) want[k*DW +: DW] = 8'h40;
    post("model_equal", pool_of(map), want);
    pulse(map);
    wait_valid(60, lat);
    post("equal_all", pool_lin, want);

    // Backpressure: result held for 20 cycles while inputs churn.
    wait_idle(60);
    out_ready = 1'b0;
    map  = rand_map();
    expv = pool_of(map);
    pulse(map);
    wait_valid(60, lat);
    for (int i = 0; i < 20; i++) begin
      in_valid = ~in_valid;
      conv_lin = rand_map();
      tick();
      post("bp_hold", pool_lin, expv);
      post("bp_in_ready", PWID'(in_ready), PWID'(0));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();

    // Reset in the middle of CALC (cnt = 10).
    wait_idle(60);
    pulse(rand_map());
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    post("rst_mid_out_valid", PWID'(out_valid), PWID'(0));
    post("rst_mid_pool", pool_lin, PWID'(0));
    post("rst_mid_in_ready", PWID'(in_ready), PWID'(1));
    tick();
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (out_valid !== 1'b0) bad++;
    end
    post("no_spurious_valid", PWID'(bad), PWID'(0));

    // Streaming: 100 random frames with both handshakes held high.
    wait_idle(60);
    out_ready  = 1'b1;
    start_done = m_done;
    in_valid   = 1'b1;
    guard      = 0;
    while (m_done < start_done + 100 && guard < 4000) begin
      if (in_ready === 1'b1) dq.push_back(guard);
      conv_lin = rand_map();
      tick();
      guard++;
    end
    in_valid = 1'b0;
    if (guard >= 4000) post("timeout_stream", PWID'(m_done - start_done), PWID'(100));
    post("stream_accepts", PWID'(dq.size() >= 100), PWID'(1));
    bad = 0;
    for (int i = 1; i < dq.size(); i++)
      if (dq[i] - dq[i-1] != NP + 2) bad++;
    post("stream_interval", PWID'(bad), PWID'(0));
    wait_idle(60);

    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pool_module.md
POOL_MODULE -- requirements
Module: pool_module

Interface
REQ-001 SHALL have parameter DW, default 8: bit width of one conv and pool element.
REQ-002 SHALL have parameter CH, default 3: number of channels.
REQ-003 SHALL have parameter IW, default 6: conv map width and height; only even values are legal.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1 bit: conv_lin holds a valid conv map.
REQ-007 SHALL have port in_ready, output, 1 bit: the block can accept a map.
REQ-008 SHALL have port conv_lin, input, IW*IW*CH*DW bits: conv map, element (c,r,k) at bits [(c*IW*IW+r*IW+k)*DW +: DW].
REQ-009 SHALL have port out_valid, output, 1 bit: pool_lin holds a complete pooled map.
REQ-010 SHALL have port out_ready, input, 1 bit: the consumer accepts pool_lin.
REQ-011 SHALL have port pool_lin, output, (IW/2)*(IW/2)*CH*DW bits: pooled map, element (c,pr,pc) at bits [(c*(IW/2)**2+pr*(IW/2)+pc)*DW +: DW].

Function
REQ-012 SHALL implement a three-state FSM:
- IDLE: in_ready=1, out_valid=0.
- CALC: in_ready=0, out_valid=0.
- DONE: in_ready=0, out_valid=1.
REQ-013 SHALL, in IDLE when in_valid=1, copy conv_lin into an internal buffer, clear the element counter cnt to 0, and enter CALC on that edge.
REQ-014 SHALL ignore in_valid and conv_lin in CALC and DONE; input changes in those states SHALL NOT affect the result.
REQ-015 SHALL, in CALC, each cycle write pool element cnt as the max of the buffered 2x2 window. For cnt -> (c,pr,pc), the window is rows 2pr..2pr+1, cols 2pc..2pc+1 of channel c.
REQ-016 SHALL increment cnt by 1 per CALC cycle. On the cycle cnt=(IW/2)**2*CH-1 (26 by default), it SHALL write the last element and enter DONE; cnt SHALL NOT wrap inside CALC.
REQ-017 SHALL assert out_valid exactly (IW/2)**2*CH cycles (27 by default) after the accepting edge, with all pool_lin elements final.
REQ-018 SHALL hold pool_lin and out_valid stable in DONE until out_ready=1; on that edge it SHALL return to IDLE.
REQ-019 SHALL keep pool_lin at its last value in IDLE; elements not yet written in CALC SHALL hold their previous-frame value.
REQ-020 SHALL decode in_ready and out_valid combinationally from the state register only, with no combinational path from in_valid or out_ready.
REQ-021 SHALL resolve window ties to the equal value; comparison rules are set by REQ-026 and REQ-027.
REQ-022 SHALL accept back-to-back frames with one IDLE cycle between DONE and the next accept, giving a throughput of 1 frame per (IW/2)**2*CH+2 cycles.

Reset
REQ-023 SHALL, on rst_n=0, asynchronously force state=IDLE, cnt=0, buffer=0 and pool_lin=0; so out_valid=0 and in_ready=1 during reset.
REQ-024 SHALL, on reset mid-CALC or mid-DONE, abandon the frame with no partial out_valid; after release the block SHALL wait in IDLE for a new in_valid.
REQ-025 SHALL respond to in_valid no earlier than the first rising edge after rst_n deasserts.

Configuration
REQ-026 SHALL, with macro POOL_RELU_EN defined, treat elements as signed two's complement: each element is clamped with max(x,0) before pooling, so all outputs are >= 0 (ReLU fused ahead of the max-pool).
REQ-027 SHALL, without POOL_RELU_EN, treat elements as unsigned and apply no clamp; 8'hFF is then the largest value.

Verification
REQ-028 SHALL cover reset: assert rst_n=0 mid-CALC (cnt=10) -> out_valid=0 and pool_lin=0 immediately; in_ready=1; no out_valid appears afterwards without a new in_valid.
REQ-029 SHALL cover a ramp map: conv element index i holds value i mod 256, in_valid pulsed with out_ready=1 -> out_valid exactly 27 cycles after accept; pool element (0,0,0)=7, (2,2,2)=107.
REQ-030 SHALL cover the clamp: a channel-0 window {8'h80,8'hFE,8'h05,8'h03} -> output 5 with POOL_RELU_EN, 8'hFE without.
REQ-031 SHALL cover backpressure: out_ready=0 for 20 cycles in DONE, with in_valid toggling and conv_lin randomised -> pool_lin unchanged, in_ready=0, result is the first frame's.
REQ-032 SHALL cover streaming: 100 random frames with in_valid=1 and out_ready=1 held -> every frame matches the golden model; frames accepted at intervals of exactly 29 cycles.
REQ-033 SHALL cover an all-equal map of 8'h40 -> all 27 outputs equal 8'h40 in both configurations.
